// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage
//   Instruction-decode stage of a 5-stage MIPS pipeline. Holds the IF/ID
//   latch, reads a 32x32 register file written by WB (with write-through
//   bypass), decodes the opcode into control bits and registers the result
//   into the ID/EX latch. Detects load-use hazards (one-cycle stall plus a
//   bubble) and honours a taken-branch flush from EX, which squashes both
//   latches.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   if_instruction    instruction word from IF
//   if_pc_plus4       PC+4 of that instruction
//   if_valid          IF output holds a real instruction
//   flush             taken branch in EX; squash IF/ID and ID/EX
//   wb_we/addr/data   register-file write port
//   stall             combinational; IF must hold PC and instruction
//   id_*              ID/EX latch contents (decoded instruction + operands)
// ---------------------------------------------------------------------------
module id_stage #(
  parameter int DATA_W   = 32,
  parameter bit RF_CLEAR = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       if_instruction,
  input  logic [31:0]       if_pc_plus4,
  input  logic              if_valid,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              id_valid,
  output logic [5:0]        id_opcode,
  output logic [5:0]        id_funct,
  output logic [DATA_W-1:0] id_rs_data,
  output logic [DATA_W-1:0] id_rt_data,
  output logic [31:0]       id_imm,
  output logic [4:0]        id_dest,
  output logic              id_reg_write,
  output logic              id_mem_read,
  output logic              id_mem_write,
  output logic              id_branch,
  output logic [31:0]       id_pc_plus4
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  // IF/ID latch
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;

  // Register file
  logic [DATA_W-1:0] rf [32];

  // Fields of the instruction sitting in IF/ID
  logic [5:0]  dec_opcode;
  logic [4:0]  dec_rs;
  logic [4:0]  dec_rt;
  logic [4:0]  dec_rd;
  logic [5:0]  dec_funct;
  logic [31:0] dec_imm;

  assign dec_opcode = ifid_instr[31:26];
  assign dec_rs     = ifid_instr[25:21];
  assign dec_rt     = ifid_instr[20:16];
  assign dec_rd     = ifid_instr[15:11];
  assign dec_funct  = ifid_instr[5:0];
  assign dec_imm    = {{16{ifid_instr[15]}}, ifid_instr[15:0]};

  // Decoded controls
  logic [4:0] dec_dest;
  logic       dec_reg_write;
  logic       dec_mem_read;
  logic       dec_mem_write;
  logic       dec_branch;

  // Destination is reported as 0 for instructions that write no register,
  // so the hazard compare never matches on a stale field.
  always_comb begin
    dec_dest      = 5'd0;
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_branch    = 1'b0;
    case (dec_opcode)
      OP_RTYPE: begin
        dec_dest      = dec_rd;
        dec_reg_write = 1'b1;
      end
      OP_LW: begin
        dec_dest      = dec_rt;
        dec_reg_write = 1'b1;
        dec_mem_read  = 1'b1;
      end
      OP_SW: begin
        dec_mem_write = 1'b1;
      end
      OP_ADDI: begin
        dec_dest      = dec_rt;
        dec_reg_write = 1'b1;
      end
      OP_BEQ: begin
        dec_branch = 1'b1;
      end
      default: ;
    endcase
  end

  // Register-file reads: r0 hardwired to zero, same-cycle WB write bypassed.
  logic [DATA_W-1:0] rs_read;
  logic [DATA_W-1:0] rt_read;

  always_comb begin
    rs_read = '0;
    if (dec_rs != 5'd0) begin
      if (wb_we && (wb_addr == dec_rs)) rs_read = wb_data;
      else                              rs_read = rf[dec_rs];
    end
  end

  always_comb begin
    rt_read = '0;
    if (dec_rt != 5'd0) begin
      if (wb_we && (wb_addr == dec_rt)) rt_read = wb_data;
      else                              rt_read = rf[dec_rt];
    end
  end

  // Register-file write port. The reset flavour is chosen at elaboration;
  // with RF_CLEAR=0 reset leaves stored values untouched.
  generate
    if (RF_CLEAR) begin : g_rf_clear
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (wb_we && (wb_addr != 5'd0)) begin
          rf[wb_addr] <= wb_data;
        end
      end
    end else begin : g_rf_keep
      always_ff @(posedge clk) begin
        if (wb_we && (wb_addr != 5'd0)) rf[wb_addr] <= wb_data;
      end
    end
  endgenerate

  // Load-use hazard: the load in ID/EX targets a source of the instruction
  // in IF/ID. Once the bubble reaches ID/EX, id_valid drops and the stall
  // releases, so each load stalls for at most one cycle. Flush and reset
  // both override it.
  assign stall = ~rst & ~flush & id_valid & id_mem_read & (id_dest != 5'd0) &
                 ifid_valid & ((id_dest == dec_rs) | (id_dest == dec_rt));

  // IF/ID latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_instr    <= '0;
      ifid_pc_plus4 <= '0;
      ifid_valid    <= 1'b0;
    end else if (flush) begin
      ifid_instr    <= '0;
      ifid_pc_plus4 <= '0;
      ifid_valid    <= 1'b0;
    end else if (!stall) begin
      ifid_instr    <= if_instruction;
      ifid_pc_plus4 <= if_pc_plus4;
      ifid_valid    <= if_valid;
    end
  end

  // ID/EX latch. Every non-instruction slot (flush, stall bubble, or an
  // IF/ID bubble) is loaded as all zeros, not only its controls.
  logic load_bubble;
  assign load_bubble = flush | stall | ~ifid_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid     <= 1'b0;
      id_opcode    <= '0;
      id_funct     <= '0;
      id_rs_data   <= '0;
      id_rt_data   <= '0;
      id_imm       <= '0;
      id_dest      <= '0;
      id_reg_write <= 1'b0;
      id_mem_read  <= 1'b0;
      id_mem_write <= 1'b0;
      id_branch    <= 1'b0;
      id_pc_plus4  <= '0;
    end else if (load_bubble) begin
      id_valid     <= 1'b0;
      id_opcode    <= '0;
      id_funct     <= '0;
      id_rs_data   <= '0;
      id_rt_data   <= '0;
      id_imm       <= '0;
      id_dest      <= '0;
      id_reg_write <= 1'b0;
      id_mem_read  <= 1'b0;
      id_mem_write <= 1'b0;
      id_branch    <= 1'b0;
      id_pc_plus4  <= '0;
    end else begin
      id_valid     <= 1'b1;
      id_opcode    <= dec_opcode;
      id_funct     <= dec_funct;
      id_rs_data   <= rs_read;
      id_rt_data   <= rt_read;
      id_imm       <= dec_imm;
      id_dest      <= dec_dest;
      id_reg_write <= dec_reg_write;
      id_mem_read  <= dec_mem_read;
      id_mem_write <= dec_mem_write;
      id_branch    <= dec_branch;
      id_pc_plus4  <= ifid_pc_plus4;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

  localparam logic [31:0] ADD_8_9_10 = 32'h012A4020;
  localparam logic [31:0] ADD_9_8_8  = 32'h01084820;
  localparam logic [31:0] ADD_8_0_0  = 32'h00004020;
  localparam logic [31:0] ADD_8_5_5  = 32'h00A54020;
  localparam logic [31:0] LW_8_4_0   = 32'h8C080004;
  localparam logic [31:0] ADDI_0_0   = 32'h2000FFFC;
  localparam logic [31:0] SW_10_8_9  = 32'hAD2A0008;
  localparam logic [31:0] BEQ_9_10   = 32'h112AFFFF;
  localparam logic [31:0] UNK_3F     = 32'hFC000000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] if_instruction = '0;
  logic [31:0] if_pc_plus4 = '0;
  logic        if_valid = 1'b0;
  logic        flush = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        stall;
  logic        id_valid;
  logic [5:0]  id_opcode;
  logic [5:0]  id_funct;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic [4:0]  id_dest;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_branch;
  logic [31:0] id_pc_plus4;

  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  id_stage #(.DATA_W(32), .RF_CLEAR(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .if_instruction(if_instruction), .if_pc_plus4(if_pc_plus4), .if_valid(if_valid),
    .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .stall(stall), .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_branch(id_branch), .id_pc_plus4(id_pc_plus4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        v;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic [31:0] pc;
  } exp_t;

  logic [31:0] m_rf [32];
  logic [31:0] m_ifid_instr;
  logic [31:0] m_ifid_pc;
  logic        m_ifid_v;
  exp_t        m_id;

  function automatic exp_t decode(input logic [31:0] ins, input logic [31:0] pc,
                                  input logic [31:0] rsd, input logic [31:0] rtd);
    exp_t e;
    e     = '0;
    e.v   = 1'b1;
    e.op  = ins[31:26];
    e.fn  = ins[5:0];
    e.rs  = rsd;
    e.rt  = rtd;
    e.imm = {{16{ins[15]}}, ins[15:0]};
    e.pc  = pc;
    case (ins[31:26])
      6'h00: begin e.dest = ins[15:11]; e.rw = 1'b1; end
      6'h23: begin e.dest = ins[20:16]; e.rw = 1'b1; e.mr = 1'b1; end
      6'h2B: e.mw = 1'b1;
      6'h08: begin e.dest = ins[20:16]; e.rw = 1'b1; end
      6'h04: e.br = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_we && wb_addr == a) return wb_data;
    return m_rf[a];
  endfunction

  function automatic logic m_stall();
    logic [4:0] s, t;
    s = m_ifid_instr[25:21];
    t = m_ifid_instr[20:16];
    if (rst || flush) return 1'b0;
    return m_id.v && m_id.mr && (m_id.dest != 5'd0) && m_ifid_v &&
           (m_id.dest == s || m_id.dest == t);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      m_ifid_instr = '0;
      m_ifid_pc    = '0;
      m_ifid_v     = 1'b0;
      m_id         = '0;
    end else begin
      logic st;
      exp_t nid;
      st = m_stall();
      if (flush || st || !m_ifid_v) nid = '0;
      else nid = decode(m_ifid_instr, m_ifid_pc,
                        m_read(m_ifid_instr[25:21]), m_read(m_ifid_instr[20:16]));
      if (flush) begin
        m_ifid_v = 1'b0;
      end else if (!st) begin
        m_ifid_instr = if_instruction;
        m_ifid_pc    = if_pc_plus4;
        m_ifid_v     = if_valid;
      end
      if (wb_we && wb_addr != 5'd0) m_rf[wb_addr] = wb_data;
      m_id = nid;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (stall) stall_cnt++;
    chk("stall",     {31'd0, stall},        {31'd0, m_stall()});
    chk("valid",     {31'd0, id_valid},     {31'd0, m_id.v});
    chk("opcode",    {26'd0, id_opcode},    {26'd0, m_id.op});
    chk("funct",     {26'd0, id_funct},     {26'd0, m_id.fn});
    chk("rs_data",   id_rs_data,            m_id.rs);
    chk("rt_data",   id_rt_data,            m_id.rt);
    chk("imm",       id_imm,                m_id.imm);
    chk("dest",      {27'd0, id_dest},      {27'd0, m_id.dest});
    chk("reg_write", {31'd0, id_reg_write}, {31'd0, m_id.rw});
    chk("mem_read",  {31'd0, id_mem_read},  {31'd0, m_id.mr});
    chk("mem_write", {31'd0, id_mem_write}, {31'd0, m_id.mw});
    chk("branch",    {31'd0, id_branch},    {31'd0, m_id.br});
    chk("pc_plus4",  id_pc_plus4,           m_id.pc);
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction; like a real IF, hold it while stall is high.
  task automatic issue(input logic [31:0] ins, input logic v);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    if_instruction = ins;
    if_valid       = v;
    if_pc_plus4    = pc_ctr + 32'd4;
    while (!acc && n < 8) begin
      @(negedge clk);
      acc = !stall;
      cyc();
      n++;
    end
    if (!acc) chk("issue_accept_timeout", {31'd0, acc}, 32'd1);
    pc_ctr = pc_ctr + 32'd4;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst = 1'b1;
    repeat (2) cyc();
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;

    // seed r10
    wb_we = 1'b1; wb_addr = 5'd10; wb_data = 32'h0000_1234;
    cyc();
    wb_we = 1'b0;

    // pipeline + bypass on rs
    issue(ADD_8_9_10, 1'b1);
    wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'hDEADBEEF;
    issue(32'd0, 1'b0);
    wb_we = 1'b0;
    chk("add_dest",   {27'd0, id_dest}, 32'd8);
    chk("add_rw",     {31'd0, id_reg_write}, 32'd1);
    chk("add_opcode", {26'd0, id_opcode}, 32'd0);
    chk("add_funct",  {26'd0, id_funct}, 32'h20);
    chk("bypass_rs",  id_rs_data, 32'hDEADBEEF);
    chk("add_rt",     id_rt_data, 32'h0000_1234);

    issue(ADD_8_9_10, 1'b1);
    issue(32'd0, 1'b0);
    chk("rf_r9", id_rs_data, 32'hDEADBEEF);

    // load-use
    begin
      int s0;
      s0 = stall_cnt;
      issue(LW_8_4_0, 1'b1);
      issue(ADD_9_8_8, 1'b1);
      chk("lu_stall",  {31'd0, stall}, 32'd1);
      chk("lu_memrd",  {31'd0, id_mem_read}, 32'd1);
      chk("lu_dest",   {27'd0, id_dest}, 32'd8);
      chk("lu_imm",    id_imm, 32'd4);
      if_valid = 1'b0;
      cyc();
      chk("lu_bubble", {31'd0, id_valid}, 32'd0);
      chk("lu_stall_released", {31'd0, stall}, 32'd0);
      cyc();
      chk("lu_add_valid", {31'd0, id_valid}, 32'd1);
      chk("lu_add_dest",  {27'd0, id_dest}, 32'd9);
      chk("lu_stall_cycles", stall_cnt - s0, 32'd1);
    end

    // flush over stall
    issue(LW_8_4_0, 1'b1);
    issue(ADD_9_8_8, 1'b1);
    chk("fs_stall_pre", {31'd0, stall}, 32'd1);
    flush = 1'b1;
    if_valid = 1'b0;
    #1;
    chk("fs_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("fs_valid", {31'd0, id_valid}, 32'd0);
    chk("fs_ifid_valid", {31'd0, u_dut.ifid_valid}, 32'd0);
    cyc();
    chk("fs_valid2", {31'd0, id_valid}, 32'd0);

    // imm sign-extension and r0
    issue(ADDI_0_0, 1'b1);
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h0000_0055;
    issue(ADD_8_0_0, 1'b1);
    wb_we = 1'b0;
    chk("addi_imm",  id_imm, 32'hFFFFFFFC);
    chk("addi_dest", {27'd0, id_dest}, 32'd0);
    chk("addi_rw",   {31'd0, id_reg_write}, 32'd1);
    chk("r0_bypass", id_rs_data, 32'd0);
    issue(32'd0, 1'b0);
    chk("r0_read_rs", id_rs_data, 32'd0);
    chk("r0_read_rt", id_rt_data, 32'd0);

    // sw / beq / unknown opcode
    issue(SW_10_8_9, 1'b1);
    issue(BEQ_9_10, 1'b1);
    chk("sw_mw",   {31'd0, id_mem_write}, 32'd1);
    chk("sw_dest", {27'd0, id_dest}, 32'd0);
    chk("sw_rt",   id_rt_data, 32'h0000_1234);
    issue(UNK_3F, 1'b1);
    chk("beq_br",  {31'd0, id_branch}, 32'd1);
    chk("beq_imm", id_imm, 32'hFFFFFFFF);
    issue(32'd0, 1'b0);
    chk("unk_valid", {31'd0, id_valid}, 32'd1);
    chk("unk_rw",    {31'd0, id_reg_write}, 32'd0);
    chk("unk_op",    {26'd0, id_opcode}, 32'h3F);

    // async reset mid-run while stalled
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_0077;
    issue(LW_8_4_0, 1'b1);
    wb_we = 1'b0;
    issue(ADD_9_8_8, 1'b1);
    chk("mr_stall_pre", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mr_valid", {31'd0, id_valid}, 32'd0);
    chk("mr_dest",  {27'd0, id_dest}, 32'd0);
    chk("mr_memrd", {31'd0, id_mem_read}, 32'd0);
    chk("mr_stall", {31'd0, stall}, 32'd0);
    cyc();
    rst = 1'b0;
    issue(ADD_8_5_5, 1'b1);
    issue(32'd0, 1'b0);
    chk("mr_rf5", id_rs_data, 32'd0);
    chk("mr_add_valid", {31'd0, id_valid}, 32'd1);

    repeat (2) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
